// File: rtl/student_iis_pkg.sv
// Shared constants and types for the I2S stereo handler and its TX FIFO.
package student_iis_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_BCLK_DIV   = 16;
  localparam int DEF_SLOT_BITS  = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/student_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a combinational head read.
module student_sync_fifo
  import student_iis_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign dout_o  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/student_iis_stereo_handler.sv
// I2S master for a stereo codec: generates MCLK/BCLK/LRCLK, serialises FIFO
// sample pairs to the DAC and deserialises ADC pairs.
module student_iis_stereo_handler
  import student_iis_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BCLK_DIV   = DEF_BCLK_DIV,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              mono_i,
  output logic              AC_MCLK,
  output logic              AC_BCLK,
  output logic              AC_LRCLK,
  input  logic              AC_ADC_SDATA,
  output logic              AC_DAC_SDATA,
  input  logic [DATA_W-1:0] tx_data_l_i,
  input  logic [DATA_W-1:0] tx_data_r_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_l_o,
  output logic [DATA_W-1:0] rx_data_r_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o
);

  localparam int BCW = $clog2(BCLK_DIV);
  localparam int SBW = $clog2(2 * SLOT_BITS);
  localparam int IW  = $clog2(DATA_W);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BCLK_DIV - 1);
  localparam logic [BCW-1:0] BC_HALF = BCW'(BCLK_DIV / 2);
  localparam logic [BCW-1:0] BC_RISE = BCW'(BCLK_DIV / 2 - 1);
  localparam logic [SBW-1:0] SB_LAST = SBW'(2 * SLOT_BITS - 1);
  localparam logic [SBW-1:0] SB_SLOT = SBW'(SLOT_BITS);
  localparam logic [SBW-1:0] SB_DW   = SBW'(DATA_W);

  logic              mclk_reg, bclk_reg, lrclk_reg, dac_reg;
  logic              run_reg, in_reset_reg;
  logic [BCW-1:0]    bc_reg, bc_next;
  logic [SBW-1:0]    sb_reg, sb_next;
  logic [DATA_W-1:0] tx_l_reg, tx_l_next, tx_r_reg, tx_r_next;
  logic [DATA_W-1:0] rx_l_shift_reg, rx_r_shift_reg;
  logic [DATA_W-1:0] rx_l_reg, rx_r_reg;
  logic              rx_valid_reg, underrun_reg;

  logic              bc_wrap, sb_wrap, frame_start;
  logic              right_next, dac_next;
  logic [SBW-1:0]    bit_next, bit_cur;
  logic [IW-1:0]     tx_idx;
  logic              right_cur, sample_en, rx_done;

  logic [2*DATA_W-1:0] fifo_dout;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign tx_ready_o = !fifo_full && !in_reset_reg;
  assign fifo_push  = tx_valid_i && tx_ready_o;
  assign fifo_pop   = frame_start && !fifo_empty;

  student_sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .din_i   ({tx_data_l_i, tx_data_r_i}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state of the frame counters and the DAC bit they select.
  always_comb begin
    bc_wrap     = (bc_reg == BC_LAST);
    sb_wrap     = (sb_reg == SB_LAST);
    frame_start = enable_i && (!run_reg || (bc_wrap && sb_wrap));
    bc_next     = '0;
    sb_next     = '0;
    if (enable_i && run_reg) begin
      bc_next = bc_wrap ? '0 : bc_reg + BCW'(1);
      sb_next = sb_reg;
      if (bc_wrap) sb_next = sb_wrap ? '0 : sb_reg + SBW'(1);
    end

    tx_l_next = tx_l_reg;
    tx_r_next = tx_r_reg;
    if (!enable_i) begin
      tx_l_next = '0;
      tx_r_next = '0;
    end else if (frame_start) begin
      if (fifo_empty) begin
        tx_l_next = '0;
        tx_r_next = '0;
      end else begin
        tx_l_next = fifo_dout[2*DATA_W-1:DATA_W];
        tx_r_next = mono_i ? fifo_dout[2*DATA_W-1:DATA_W] : fifo_dout[DATA_W-1:0];
      end
    end

    right_next = (sb_next >= SB_SLOT);
    bit_next   = right_next ? sb_next - SB_SLOT : sb_next;
    tx_idx     = IW'(SB_DW - bit_next);
    dac_next   = 1'b0;
    if (enable_i && bit_next != '0 && bit_next <= SB_DW)
      dac_next = right_next ? tx_r_next[tx_idx] : tx_l_next[tx_idx];
  end

  // ADC is captured on the clock edge that raises BCLK.
  always_comb begin
    right_cur = (sb_reg >= SB_SLOT);
    bit_cur   = right_cur ? sb_reg - SB_SLOT : sb_reg;
    sample_en = enable_i && run_reg && (bc_reg == BC_RISE) &&
                bit_cur != '0 && bit_cur <= SB_DW;
    rx_done   = sample_en && right_cur && (bit_cur == SB_DW);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mclk_reg       <= 1'b0;
      bclk_reg       <= 1'b0;
      lrclk_reg      <= 1'b0;
      dac_reg        <= 1'b0;
      run_reg        <= 1'b0;
      in_reset_reg   <= 1'b1;
      bc_reg         <= '0;
      sb_reg         <= '0;
      tx_l_reg       <= '0;
      tx_r_reg       <= '0;
      rx_l_shift_reg <= '0;
      rx_r_shift_reg <= '0;
      rx_l_reg       <= '0;
      rx_r_reg       <= '0;
      rx_valid_reg   <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      mclk_reg     <= ~mclk_reg;
      in_reset_reg <= 1'b0;
      run_reg      <= enable_i;
      bc_reg       <= bc_next;
      sb_reg       <= sb_next;
      bclk_reg     <= (bc_next >= BC_HALF);
      lrclk_reg    <= right_next;
      dac_reg      <= dac_next;
      tx_l_reg     <= tx_l_next;
      tx_r_reg     <= tx_r_next;
      underrun_reg <= frame_start && fifo_empty;
      rx_valid_reg <= rx_done;

      if (!enable_i) begin
        rx_l_shift_reg <= '0;
        rx_r_shift_reg <= '0;
      end else if (sample_en) begin
        if (right_cur) rx_r_shift_reg <= {rx_r_shift_reg[DATA_W-2:0], AC_ADC_SDATA};
        else           rx_l_shift_reg <= {rx_l_shift_reg[DATA_W-2:0], AC_ADC_SDATA};
      end

      // The final right bit is merged directly so both words land together.
      if (rx_done) begin
        rx_l_reg <= rx_l_shift_reg;
        rx_r_reg <= mono_i ? rx_l_shift_reg : {rx_r_shift_reg[DATA_W-2:0], AC_ADC_SDATA};
      end
    end
  end

  assign AC_MCLK       = mclk_reg;
  assign AC_BCLK       = bclk_reg;
  assign AC_LRCLK      = lrclk_reg;
  assign AC_DAC_SDATA  = dac_reg;
  assign rx_data_l_o   = rx_l_reg;
  assign rx_data_r_o   = rx_r_reg;
  assign rx_valid_o    = rx_valid_reg;
  assign tx_underrun_o = underrun_reg;

endmodule

// File: tb/tb_student_iis_stereo_handler.sv
// Loopback scoreboard bench for the I2S handler (16-bit default and 24-bit instances).
module tb_student_iis_stereo_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en16, en24, mono16, mono24, v16, v24;
  logic [15:0] tl16, tr16;
  logic [23:0] tl24, tr24;

  logic        mclk16, bclk16, lr16, dac16, rdy16, rxv16, und16;
  logic [15:0] rxl16, rxr16;
  logic        mclk24, bclk24, lr24, dac24, rdy24, rxv24, und24;
  logic [23:0] rxl24, rxr24;

  student_iis_stereo_handler dut16 (
    .clk_i(clk), .rst_i(rst), .enable_i(en16), .mono_i(mono16),
    .AC_MCLK(mclk16), .AC_BCLK(bclk16), .AC_LRCLK(lr16),
    .AC_ADC_SDATA(dac16), .AC_DAC_SDATA(dac16),
    .tx_data_l_i(tl16), .tx_data_r_i(tr16), .tx_valid_i(v16), .tx_ready_o(rdy16),
    .rx_data_l_o(rxl16), .rx_data_r_o(rxr16), .rx_valid_o(rxv16), .tx_underrun_o(und16)
  );

  student_iis_stereo_handler #(.DATA_W(24), .SLOT_BITS(32)) dut24 (
    .clk_i(clk), .rst_i(rst), .enable_i(en24), .mono_i(mono24),
    .AC_MCLK(mclk24), .AC_BCLK(bclk24), .AC_LRCLK(lr24),
    .AC_ADC_SDATA(dac24), .AC_DAC_SDATA(dac24),
    .tx_data_l_i(tl24), .tx_data_r_i(tr24), .tx_valid_i(v24), .tx_ready_o(rdy24),
    .rx_data_l_o(rxl24), .rx_data_r_o(rxr24), .rx_valid_o(rxv24), .tx_underrun_o(und24)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] q16[$];
  logic [47:0] q24[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitors: pop the expected pair whenever a DUT presents one.
  logic pv16 = 1'b0, pv24 = 1'b0;
  int und_cnt = 0, und_last = 0, und_period = 0, dac_ones = 0;
  always @(negedge clk) begin
    if (rxv16) begin
      $display("rx16 l=%h r=%h", rxl16, rxr16);
      check("rx16_valid_width", 64'(pv16), 64'd0);
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL rx16_unexpected: got %h_%h expected no pair", rxl16, rxr16);
      end else begin
        check("rx16_pair", 64'({rxl16, rxr16}), 64'(q16.pop_front()));
      end
    end
    pv16 = rxv16;
    if (rxv24) begin
      $display("rx24 l=%h r=%h", rxl24, rxr24);
      check("rx24_valid_width", 64'(pv24), 64'd0);
      if (q24.size() == 0) begin
        total++; bad++;
        $display("FAIL rx24_unexpected: got %h_%h expected no pair", rxl24, rxr24);
      end else begin
        check("rx24_pair", 64'({rxl24, rxr24}), 64'(q24.pop_front()));
      end
    end
    pv24 = rxv24;
    if (und16) begin
      und_cnt++;
      und_period = cyc - und_last;
      und_last = cyc;
    end
    if (dac16) dac_ones++;
  end

  // DAC deserialisers: bit index restarts at every LRCLK change.
  int b16 = 0, b24 = 0, tail16 = 0, tail24 = 0;
  logic lrl16 = 1'b1, lrl24 = 1'b1;
  logic [15:0] w16 = '0, lw16 = '0, rw16 = '0;
  logic [23:0] w24 = '0, lw24 = '0, rw24 = '0;
  always @(posedge bclk16 or posedge rst or negedge en16) begin
    if (rst || !en16) lrl16 = 1'b1;
    else begin
      if (lr16 != lrl16) b16 = 0; else b16++;
      lrl16 = lr16;
      if (b16 >= 1 && b16 <= 16) w16 = {w16[14:0], dac16};
      if (b16 > 16 && dac16) tail16++;
      if (b16 == 16) begin
        if (lr16) rw16 = w16; else lw16 = w16;
      end
    end
  end
  always @(posedge bclk24 or posedge rst or negedge en24) begin
    if (rst || !en24) lrl24 = 1'b1;
    else begin
      if (lr24 != lrl24) b24 = 0; else b24++;
      lrl24 = lr24;
      if (b24 >= 1 && b24 <= 24) w24 = {w24[22:0], dac24};
      if (b24 > 24 && dac24) tail24++;
      if (b24 == 24) begin
        if (lr24) rw24 = w24; else lw24 = w24;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({"zero16_", tag}, 64'({mclk16, bclk16, lr16, dac16, rdy16, rxv16, und16, rxl16, rxr16}), 64'd0);
    check({"zero24_", tag}, 64'({mclk24, bclk24, lr24, dac24, rdy24, rxv24, und24, rxl24, rxr24}), 64'd0);
  endtask

  task automatic push(input bit wide, input logic [23:0] l, input logic [23:0] r, output int waited);
    @(negedge clk);
    if (wide) begin tl24 = l; tr24 = r; v24 = 1'b1; end
    else begin tl16 = l[15:0]; tr16 = r[15:0]; v16 = 1'b1; end
    waited = 0;
    while (((wide ? rdy24 : rdy16) == 1'b0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    v16 = 1'b0;
    v24 = 1'b0;
    $display("push wide=%0d l=%h r=%h waited=%0d", wide, l, r, waited);
  endtask

  task automatic run_frames(input bit wide, input int n);
    @(negedge clk);
    if (wide) en24 = 1'b1; else en16 = 1'b1;
    repeat (n * 1024 - 100) @(negedge clk);
    en16 = 1'b0;
    en24 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  logic [31:0] pairs [5] = '{32'h0001_FFFF, 32'h8000_7FFF, 32'h5555_AAAA, 32'hC3C3_3C3C, 32'h0F0F_F0F0};

  initial begin
    int w, u0, d0, errs;
    logic pm;
    rst = 1'b1; en16 = 1'b0; en24 = 1'b0; mono16 = 1'b0; mono24 = 1'b0;
    v16 = 1'b0; v24 = 1'b0; tl16 = '0; tr16 = '0; tl24 = '0; tr24 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready16_after_reset", 64'(rdy16), 64'd1);
    check("ready24_after_reset", 64'(rdy24), 64'd1);
    check("bclk_idle", 64'({bclk16, lr16, dac16}), 64'd0);
    errs = 0;
    pm = mclk16;
    repeat (10) begin
      @(negedge clk);
      if (mclk16 == pm) errs++;
      pm = mclk16;
    end
    check("mclk_toggle", 64'(errs), 64'd0);

    // Empty FIFO: every frame underruns and the DAC stays silent.
    u0 = und_cnt; d0 = dac_ones;
    repeat (3) q16.push_back(32'h0);
    run_frames(1'b0, 3);
    check("underrun_count", 64'(und_cnt - u0), 64'd3);
    check("dac_silent", 64'(dac_ones - d0), 64'd0);
    check("frame_period", 64'(und_period), 64'd1024);

    // Loopback of one pair, followed by an underrun frame.
    u0 = und_cnt;
    push(1'b0, 24'h8001, 24'h7FFE, w);
    q16.push_back(32'h8001_7FFE);
    q16.push_back(32'h0);
    run_frames(1'b0, 2);
    check("underrun_after_pair", 64'(und_cnt - u0), 64'd1);

    // FIFO fill: ready drops after four, fifth goes in once a frame pops.
    u0 = und_cnt;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, {8'h0, pairs[i][31:16]}, {8'h0, pairs[i][15:0]}, w);
      check("fill_push_wait", 64'(w), 64'd0);
      q16.push_back(pairs[i]);
    end
    check("ready_low_full", 64'(rdy16), 64'd0);
    @(negedge clk);
    en16 = 1'b1;
    push(1'b0, {8'h0, pairs[4][31:16]}, {8'h0, pairs[4][15:0]}, w);
    check("fifth_push_wait", 64'(w), 64'd0);
    q16.push_back(pairs[4]);
    repeat (5 * 1024 - 100 - 2) @(negedge clk);
    en16 = 1'b0;
    repeat (20) @(negedge clk);
    check("no_underrun_full_run", 64'(und_cnt - u0), 64'd0);

    // Mono: right slot repeats the left sample.
    mono16 = 1'b1;
    push(1'b0, 24'h1234, 24'hFFFF, w);
    q16.push_back(32'h1234_1234);
    run_frames(1'b0, 1);
    mono16 = 1'b0;
    check("mono_left_word", 64'(lw16), 64'h1234);
    check("mono_right_word", 64'(rw16), 64'h1234);

    // 24-bit instance loopback.
    push(1'b1, 24'hABCDEF, 24'h123456, w);
    check("push24_wait", 64'(w), 64'd0);
    q24.push_back(48'hABCDEF_123456);
    run_frames(1'b1, 1);
    check("dac24_left_word", 64'(lw24), 64'hABCDEF);
    check("dac24_right_word", 64'(rw24), 64'h123456);
    check("dac24_tail_zero", 64'(tail24), 64'd0);

    // Reset 300 cycles into a frame with one pair still queued.
    u0 = und_cnt;
    push(1'b0, 24'hA5A5, 24'h5A5A, w);
    push(1'b0, 24'h0F0F, 24'hF0F0, w);
    @(negedge clk);
    en16 = 1'b1;
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_frame");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", 64'(rdy16), 64'd1);
    check("underrun_on_restart", 64'(und16), 64'd1);
    q16.push_back(32'h0);
    repeat (1024 - 100 - 1) @(negedge clk);
    en16 = 1'b0;
    repeat (20) @(negedge clk);
    check("underrun_mid_reset", 64'(und_cnt - u0), 64'd1);

    check("dac16_tail_zero", 64'(tail16), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);
    check("q24_drained", 64'(q24.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
